// File: rtl/gshare_pkg.sv
// gshare_pkg: shared types and helpers for the gshare pattern history table.
//   ctr_t           2-bit saturating direction counter
//   CTR_*           counter encodings (strong/weak not-taken/taken)
//   ctr_sat_update  saturating increment on taken, decrement on not-taken
//   state_t         table controller state (INIT sweep, RUN)
package gshare_pkg;

  typedef logic [1:0] ctr_t;

  localparam ctr_t CTR_SNT = 2'b00;
  localparam ctr_t CTR_WNT = 2'b01;
  localparam ctr_t CTR_WT  = 2'b10;
  localparam ctr_t CTR_STK = 2'b11;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic ctr_t ctr_sat_update(input ctr_t c, input logic taken);
    ctr_t r;
    if (taken) begin
      r = (c == CTR_STK) ? CTR_STK : ctr_t'(c + 2'b01);
    end else begin
      r = (c == CTR_SNT) ? CTR_SNT : ctr_t'(c - 2'b01);
    end
    return r;
  endfunction

endpackage

// File: rtl/gshare_fold.sv
// gshare_fold: combinational index hash for the gshare predictor.
// The history vector is cut into IDX_W-bit chunks starting at bit 0 (last
// chunk zero-padded); all chunks are XORed together and with PC[IDX_W+1:2].
// Ports:
//   hist     in  HIST_LEN  global history, bit 0 most recent
//   pc_bits  in  IDX_W     PC bits [IDX_W+1:2] of the branch
//   idx      out IDX_W     table index
module gshare_fold
  import gshare_pkg::*;
#(
  parameter int HIST_LEN = 64,
  parameter int IDX_W    = 12
) (
  input  logic [HIST_LEN-1:0] hist,
  input  logic [IDX_W-1:0]    pc_bits,
  output logic [IDX_W-1:0]    idx
);

  localparam int NCHUNK = (HIST_LEN + IDX_W - 1) / IDX_W;
  localparam int PAD_W  = NCHUNK * IDX_W;

  logic [PAD_W-1:0] hist_pad;

  always_comb begin
    hist_pad                 = '0;
    hist_pad[HIST_LEN-1:0]   = hist;
    idx                      = pc_bits;
    for (int i = 0; i < NCHUNK; i++) begin
      idx = idx ^ hist_pad[i*IDX_W +: IDX_W];
    end
  end

endmodule

// File: rtl/gshare_pht.sv
// gshare_pht: gshare pattern history table of 2-bit saturating counters.
// After reset the table is swept to weak-not-taken, one entry per cycle;
// then predictions (1-cycle registered response) and two-stage
// read-modify-write updates are served, one of each per cycle.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   hist                     parallel global history (bit 0 most recent)
//   pred_valid, pred_pc      prediction request
//   pred_ready               high in RUN
//   resp_valid/taken/idx     registered prediction response
//   upd_valid/idx/taken      resolved-branch training input
// Configuration macro: GSHARE_BYPASS_EN -- when defined, a prediction that
// reads the entry being written by the update write stage sees the new value.
module gshare_pht
  import gshare_pkg::*;
#(
  parameter int HIST_LEN = 64,
  parameter int IDX_W    = 12,
  parameter int PC_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [HIST_LEN-1:0] hist,
  input  logic                pred_valid,
  input  logic [PC_W-1:0]     pred_pc,
  output logic                pred_ready,
  output logic                resp_valid,
  output logic                resp_taken,
  output logic [IDX_W-1:0]    resp_idx,
  input  logic                upd_valid,
  input  logic [IDX_W-1:0]    upd_idx,
  input  logic                upd_taken
);

  localparam int DEPTH = 1 << IDX_W;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] sweep_q, sweep_d;

  logic             resp_valid_q, resp_valid_d;
  logic             resp_taken_q, resp_taken_d;
  logic [IDX_W-1:0] resp_idx_q, resp_idx_d;

  logic             upd_vld_p1_q, upd_vld_p1_d;
  logic [IDX_W-1:0] upd_idx_p1_q, upd_idx_p1_d;
  ctr_t             upd_ctr_p1_q, upd_ctr_p1_d;

  ctr_t             pht_q [DEPTH];

  logic [IDX_W-1:0] pred_idx;
  ctr_t             pred_ctr;
  ctr_t             upd_rd_ctr;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  ctr_t             wr_ctr;

  gshare_fold #(
    .HIST_LEN(HIST_LEN),
    .IDX_W   (IDX_W)
  ) u_fold (
    .hist   (hist),
    .pc_bits(pred_pc[IDX_W+1:2]),
    .idx    (pred_idx)
  );

  // PC bits outside the hash window and the counter LSB do not affect the
  // prediction.
  logic unused_bits;
  assign unused_bits = ^{pred_pc, pred_ctr[0]};

  always_comb begin
    state_d      = state_q;
    sweep_d      = sweep_q;
    resp_valid_d = 1'b0;
    resp_taken_d = resp_taken_q;
    resp_idx_d   = resp_idx_q;
    upd_vld_p1_d = 1'b0;
    upd_idx_p1_d = upd_idx_p1_q;
    upd_ctr_p1_d = upd_ctr_p1_q;
    wr_en        = 1'b0;
    wr_idx       = upd_idx_p1_q;
    wr_ctr       = upd_ctr_p1_q;

    // Update read sees the value still waiting in the write stage so that
    // back-to-back updates to one entry accumulate.
    upd_rd_ctr = pht_q[upd_idx];
    if (upd_vld_p1_q && (upd_idx_p1_q == upd_idx)) begin
      upd_rd_ctr = upd_ctr_p1_q;
    end

    pred_ctr = pht_q[pred_idx];
`ifdef GSHARE_BYPASS_EN
    if (upd_vld_p1_q && (upd_idx_p1_q == pred_idx)) begin
      pred_ctr = upd_ctr_p1_q;
    end
`endif

    case (state_q)
      INIT: begin
        wr_en   = 1'b1;
        wr_idx  = sweep_q;
        wr_ctr  = CTR_WNT;
        sweep_d = sweep_q + 1'b1;
        if (sweep_q == '1) begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Write stage of the update pipeline.
        wr_en = upd_vld_p1_q;
        if (pred_valid) begin
          resp_valid_d = 1'b1;
          resp_taken_d = pred_ctr[1];
          resp_idx_d   = pred_idx;
        end
        // Read stage of the update pipeline.
        if (upd_valid) begin
          upd_vld_p1_d = 1'b1;
          upd_idx_p1_d = upd_idx;
          upd_ctr_p1_d = ctr_sat_update(upd_rd_ctr, upd_taken);
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= INIT;
      sweep_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_taken_q <= 1'b0;
      resp_idx_q   <= '0;
      upd_vld_p1_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sweep_q      <= sweep_d;
      resp_valid_q <= resp_valid_d;
      resp_taken_q <= resp_taken_d;
      resp_idx_q   <= resp_idx_d;
      upd_vld_p1_q <= upd_vld_p1_d;
    end
  end

  // ---- update write stage (p1) data ----
  always_ff @(posedge clk) begin
    upd_idx_p1_q <= upd_idx_p1_d;
    upd_ctr_p1_q <= upd_ctr_p1_d;
  end

  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      pht_q[wr_idx] <= wr_ctr;
    end
  end

  assign pred_ready = (state_q == RUN);
  assign resp_valid = resp_valid_q;
  assign resp_taken = resp_taken_q;
  assign resp_idx   = resp_idx_q;

endmodule
